// File: rtl/dtw_pkg.sv
// ---------------------------------------------------------------------------
// dtw_pkg
// Shared definitions for the DTW result filter:
//   - dtw_state_e : filter FSM state encoding (exposed on the debug port)
//   - W_QID/W_POS/W_VAL : word index of each field inside a 3-word record
//   - MATCH_BIT   : bit of the third output word that carries the match flag
// Helper functions classify states of the read phase.
// ---------------------------------------------------------------------------
package dtw_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RD_QID  = 3'd1,
    ST_RD_POS  = 3'd2,
    ST_RD_VAL  = 3'd3,
    ST_OUT_QID = 3'd4,
    ST_OUT_POS = 3'd5,
    ST_OUT_VAL = 3'd6
  } dtw_state_e;

  localparam logic [1:0] W_QID = 2'd0;
  localparam logic [1:0] W_POS = 2'd1;
  localparam logic [1:0] W_VAL = 2'd2;

  localparam int MATCH_BIT = 31;

  // True in the three states that pop one FIFO word each.
  function automatic logic is_read_state(input dtw_state_e s);
    return (s == ST_RD_QID) || (s == ST_RD_POS) || (s == ST_RD_VAL);
  endfunction

  // Record word index that a read state captures.
  function automatic logic [1:0] read_index(input dtw_state_e s);
    logic [1:0] idx;
    case (s)
      ST_RD_POS: idx = W_POS;
      ST_RD_VAL: idx = W_VAL;
      default:   idx = W_QID;
    endcase
    return idx;
  endfunction

endpackage

// File: rtl/dtw_axis_out_reg.sv
// ---------------------------------------------------------------------------
// dtw_axis_out_reg
// Single-entry AXI-Stream output register. Holds tdata/tlast/tvalid.
// Ports:
//   clk, rst      : clock, asynchronous active-low reset (clears everything)
//   load_i        : capture data_i/last_i and raise tvalid
//   data_i,last_i : beat to load
//   clear_i       : drop tvalid/tlast (data is kept)
//   tdata_o, tlast_o, tvalid_o : registered stream outputs
// The owner only loads/clears on a completed handshake, so the outputs stay
// stable while the sink stalls.
// ---------------------------------------------------------------------------
module dtw_axis_out_reg #(
  parameter int AXIS_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load_i,
  input  logic [AXIS_WIDTH-1:0] data_i,
  input  logic                  last_i,
  input  logic                  clear_i,
  output logic [AXIS_WIDTH-1:0] tdata_o,
  output logic                  tlast_o,
  output logic                  tvalid_o
);

  logic [AXIS_WIDTH-1:0] tdata_q;
  logic                  tlast_q;
  logic                  tvalid_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tdata_q  <= '0;
      tlast_q  <= 1'b0;
      tvalid_q <= 1'b0;
    end else if (load_i) begin
      tdata_q  <= data_i;
      tlast_q  <= last_i;
      tvalid_q <= 1'b1;
    end else if (clear_i) begin
      tlast_q  <= 1'b0;
      tvalid_q <= 1'b0;
    end
  end

  assign tdata_o  = tdata_q;
  assign tlast_o  = tlast_q;
  assign tvalid_o = tvalid_q;

endmodule

// File: rtl/dtw_result_filter.sv
// ---------------------------------------------------------------------------
// dtw_result_filter
// Reads 3-word DTW result records {qid, position, minval} from an FWFT FIFO,
// flags a match when minval <= threshold, counts records and matches, and
// re-emits each record as a 3-beat AXI-Stream packet:
//   qid, position, {match, 15'b0, minval}  (tlast on the third beat)
// Build option: define DTW_FILTER_DROP_EN to discard non-matching records
// (they are still counted in n_records).
// Ports:
//   clk, rst           : clock, asynchronous active-low reset
//   enable             : allows a new record read to start from IDLE
//   threshold          : unsigned match limit, sampled when minval is popped
//   res_fifo_rden/empty/data : FWFT FIFO pop, empty flag, head word
//   m_axis_tdata/tvalid/tready/tlast : AXI-Stream master
//   busy               : FSM not in IDLE
//   n_records, n_match : wrapping 32-bit record / match counters
//   cnt_preset, cnt_preset_val : load both counters with a value
//   dbg_state          : current FSM state
// Stream handshake: a beat transfers on a clock edge where tvalid && tready;
// once tvalid is raised the beat (tdata/tlast) is held until that edge.
// ---------------------------------------------------------------------------
module dtw_result_filter
  import dtw_pkg::*;
#(
  parameter int WIDTH      = 16,
  parameter int AXIS_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic [WIDTH-1:0]      threshold,
  output logic                  res_fifo_rden,
  input  logic                  res_fifo_empty,
  input  logic [AXIS_WIDTH-1:0] res_fifo_data,
  output logic [AXIS_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  output logic                  busy,
  output logic [31:0]           n_records,
  output logic [31:0]           n_match,
  input  logic                  cnt_preset,
  input  logic [31:0]           cnt_preset_val,
  output logic [2:0]            dbg_state
);

  dtw_state_e state_q, state_d;

  logic [AXIS_WIDTH-1:0] qid_q, pos_q, val_q;
  logic [31:0]           n_records_q, n_records_d;
  logic [31:0]           n_match_q, n_match_d;

  logic                  rd_fire;
  logic                  hs;
  logic                  cap_en;
  logic [1:0]            cap_idx;
  logic [AXIS_WIDTH-1:0] cap_data;
  logic [WIDTH-1:0]      minval;
  logic                  match;
  logic [AXIS_WIDTH-1:0] val_word;

  logic                  out_load;
  logic [AXIS_WIDTH-1:0] out_data;
  logic                  out_last;
  logic                  out_clear;

  // Match decision on the head word while in RD_VAL; only used on a pop.
  assign minval = res_fifo_data[WIDTH-1:0];
  assign match  = (minval <= threshold);
  assign hs     = m_axis_tvalid && m_axis_tready;

  always_comb begin
    val_word            = '0;
    val_word[WIDTH-1:0] = minval;
    val_word[MATCH_BIT] = match;
  end

  // A read state pops only when the FIFO shows data, so rden never
  // coincides with empty.
  assign rd_fire       = is_read_state(state_q) && !res_fifo_empty;
  assign res_fifo_rden = rd_fire;
  assign cap_en        = rd_fire;
  assign cap_idx       = read_index(state_q);
  assign cap_data      = (state_q == ST_RD_VAL) ? val_word : res_fifo_data;

  // Next state and output-register control.
  always_comb begin
    state_d   = state_q;
    out_load  = 1'b0;
    out_data  = '0;
    out_last  = 1'b0;
    out_clear = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (enable) state_d = ST_RD_QID;
      end
      ST_RD_QID: begin
        if (rd_fire) state_d = ST_RD_POS;
      end
      ST_RD_POS: begin
        if (rd_fire) state_d = ST_RD_VAL;
      end
      ST_RD_VAL: begin
        if (rd_fire) begin
`ifdef DTW_FILTER_DROP_EN
          if (!match) begin
            state_d = ST_IDLE;
          end else begin
            out_load = 1'b1;
            out_data = qid_q;
            state_d  = ST_OUT_QID;
          end
`else
          out_load = 1'b1;
          out_data = qid_q;
          state_d  = ST_OUT_QID;
`endif
        end
      end
      ST_OUT_QID: begin
        if (hs) begin
          out_load = 1'b1;
          out_data = pos_q;
          state_d  = ST_OUT_POS;
        end
      end
      ST_OUT_POS: begin
        if (hs) begin
          out_load = 1'b1;
          out_data = val_q;
          out_last = 1'b1;
          state_d  = ST_OUT_VAL;
        end
      end
      ST_OUT_VAL: begin
        if (hs) begin
          out_clear = 1'b1;
          state_d   = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Counters advance in the RD_VAL pop cycle; a preset takes priority.
  always_comb begin
    n_records_d = n_records_q;
    n_match_d   = n_match_q;
    if (cnt_preset) begin
      n_records_d = cnt_preset_val;
      n_match_d   = cnt_preset_val;
    end else if (rd_fire && (state_q == ST_RD_VAL)) begin
      n_records_d = n_records_q + 32'd1;
      if (match) n_match_d = n_match_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      n_records_q <= '0;
      n_match_q   <= '0;
    end else begin
      state_q     <= state_d;
      n_records_q <= n_records_d;
      n_match_q   <= n_match_d;
    end
  end

  // Record capture, same cycle as the pop.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      qid_q <= '0;
      pos_q <= '0;
      val_q <= '0;
    end else if (cap_en) begin
      case (cap_idx)
        W_QID:   qid_q <= cap_data;
        W_POS:   pos_q <= cap_data;
        W_VAL:   val_q <= cap_data;
        default: ;
      endcase
    end
  end

  dtw_axis_out_reg #(
    .AXIS_WIDTH(AXIS_WIDTH)
  ) u_out_reg (
    .clk      (clk),
    .rst      (rst),
    .load_i   (out_load),
    .data_i   (out_data),
    .last_i   (out_last),
    .clear_i  (out_clear),
    .tdata_o  (m_axis_tdata),
    .tlast_o  (m_axis_tlast),
    .tvalid_o (m_axis_tvalid)
  );

  assign busy      = (state_q != ST_IDLE);
  assign n_records = n_records_q;
  assign n_match   = n_match_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_dtw_result_filter.sv
// ---------------------------------------------------------------------------
// tb_dtw_result_filter
// Bench for dtw_result_filter: an FWFT FIFO model feeds records, the bench
// predicts stream beats and counter values from the record contents and the
// threshold, and compares at the falling clock edge.
// ---------------------------------------------------------------------------
module tb_dtw_result_filter;
  import dtw_pkg::*;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst;
  always #5 clk = ~clk;

  logic        enable;
  logic [15:0] threshold;
  logic        res_fifo_rden;
  logic        res_fifo_empty;
  logic [31:0] res_fifo_data;
  logic [31:0] m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tready;
  logic        m_axis_tlast;
  logic        busy;
  logic [31:0] n_records;
  logic [31:0] n_match;
  logic        cnt_preset;
  logic [31:0] cnt_preset_val;
  logic [2:0]  dbg_state;

  dtw_result_filter #(.WIDTH(16), .AXIS_WIDTH(32)) dut (
    .clk            (clk),
    .rst            (rst),
    .enable         (enable),
    .threshold      (threshold),
    .res_fifo_rden  (res_fifo_rden),
    .res_fifo_empty (res_fifo_empty),
    .res_fifo_data  (res_fifo_data),
    .m_axis_tdata   (m_axis_tdata),
    .m_axis_tvalid  (m_axis_tvalid),
    .m_axis_tready  (m_axis_tready),
    .m_axis_tlast   (m_axis_tlast),
    .busy           (busy),
    .n_records      (n_records),
    .n_match        (n_match),
    .cnt_preset     (cnt_preset),
    .cnt_preset_val (cnt_preset_val),
    .dbg_state      (dbg_state)
  );

  // ---------------- FWFT FIFO model ----------------
  logic [31:0] mem [0:255];
  logic [31:0] wr_ptr = 32'd0;
  logic [31:0] rd_ptr = 32'd0;

  assign res_fifo_empty = (rd_ptr == wr_ptr);
  assign res_fifo_data  = mem[rd_ptr[7:0]];

  always @(posedge clk)
    if (res_fifo_rden && !res_fifo_empty) rd_ptr <= rd_ptr + 32'd1;

  // ---------------- scoreboard ----------------
  logic [32:0] exp_q[$];          // {tlast, tdata}
  logic [31:0] exp_rec = 32'd0;
  logic [31:0] exp_match = 32'd0;
  int          vectors = 0;
  int          miscompares = 0;

  logic [31:0] r_qid [4];
  logic [31:0] r_pos [4];
  logic [15:0] r_min [4];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic push(input logic [31:0] w);
    mem[wr_ptr[7:0]] = w;
    wr_ptr = wr_ptr + 32'd1;
  endtask

  // Reference: a record matches when minval <= threshold; the third beat
  // carries the flag in bit 31 above the zero-extended minval.
  task automatic predict(input int i);
    logic m;
    m = (r_min[i] <= threshold);
    exp_rec = exp_rec + 32'd1;
    if (m) exp_match = exp_match + 32'd1;
`ifdef DTW_FILTER_DROP_EN
    if (m) begin
`else
    begin
`endif
      exp_q.push_back({1'b0, r_qid[i]});
      exp_q.push_back({1'b0, r_pos[i]});
      exp_q.push_back({1'b1, m, 15'd0, r_min[i]});
    end
  endtask

  // rmode: 0 random tready, 1 tready always high, 2 tready low 5 cycles on beat 1
  // stall: >0 holds back words 1/2 for that many empty cycles (nrec must be 1)
  task automatic run_batch(input int nrec, input bit hold_en, input int stall, input int rmode);
    int cyc, low_cnt, stall_cnt;
    bit pend, done, prev_wait;
    logic [31:0] prev_d;
    logic prev_l;
    logic [32:0] e;
    cyc = 0; low_cnt = 0; stall_cnt = 0; done = 0; prev_wait = 0;
    prev_d = '0; prev_l = 1'b0;
    pend = (stall > 0);
    for (int i = 0; i < nrec; i++) begin
      predict(i);
      push(r_qid[i]);
      if (!pend) begin
        push(r_pos[i]);
        push({16'd0, r_min[i]});
      end
    end
    @(negedge clk);
    enable = 1'b1;
    while (!done && cyc < 400) begin
      @(negedge clk);
      cyc++;
      if (!hold_en) enable = 1'b0;
      else if (rd_ptr == wr_ptr) enable = 1'b0;
      if (pend && rd_ptr == wr_ptr) begin
        check("stall_rden", {63'd0, res_fifo_rden}, 64'd0);
        stall_cnt++;
        if (stall_cnt == stall) begin
          push(r_pos[0]);
          push({16'd0, r_min[0]});
          pend = 0;
        end
      end
      case (rmode)
        1: m_axis_tready = 1'b1;
        2: begin
          if ((3 - exp_q.size()) == 1 && m_axis_tvalid && low_cnt < 5) begin
            m_axis_tready = 1'b0;
            low_cnt++;
          end else m_axis_tready = 1'b1;
        end
        default: m_axis_tready = ($urandom_range(0, 99) < 70);
      endcase
      #1;
      check("rden_when_empty", {63'd0, res_fifo_rden & res_fifo_empty}, 64'd0);
      check("pop_during_out", {63'd0, res_fifo_rden & m_axis_tvalid}, 64'd0);
      if (prev_wait) begin
        check("hold_valid", {63'd0, m_axis_tvalid}, 64'd1);
        check("hold_data", {32'd0, m_axis_tdata}, {32'd0, prev_d});
        check("hold_last", {63'd0, m_axis_tlast}, {63'd0, prev_l});
      end
      if (m_axis_tvalid && m_axis_tready) begin
        check("beat_expected", {63'd0, exp_q.size() != 0}, 64'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("beat", {31'd0, m_axis_tlast, m_axis_tdata}, {31'd0, e});
        end
      end
      prev_wait = m_axis_tvalid && !m_axis_tready;
      prev_d = m_axis_tdata;
      prev_l = m_axis_tlast;
      done = (exp_q.size() == 0) && !pend && (rd_ptr == wr_ptr) && !busy && !enable;
    end
    check("batch_done", {63'd0, done}, 64'd1);
    exp_q.delete();
    check("n_records", {32'd0, n_records}, {32'd0, exp_rec});
    check("n_match", {32'd0, n_match}, {32'd0, exp_match});
  endtask

  task automatic set_rec(input int i, input logic [31:0] q, input logic [31:0] p, input logic [15:0] m);
    r_qid[i] = q; r_pos[i] = p; r_min[i] = m;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rden"},   {63'd0, res_fifo_rden}, 64'd0);
    check({tag, "_tvalid"}, {63'd0, m_axis_tvalid}, 64'd0);
    check({tag, "_tlast"},  {63'd0, m_axis_tlast}, 64'd0);
    check({tag, "_tdata"},  {32'd0, m_axis_tdata}, 64'd0);
    check({tag, "_busy"},   {63'd0, busy}, 64'd0);
    check({tag, "_nrec"},   {32'd0, n_records}, 64'd0);
    check({tag, "_nmatch"}, {32'd0, n_match}, 64'd0);
    check({tag, "_state"},  {61'd0, dbg_state}, {61'd0, ST_IDLE});
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    int k;
    logic [16:0] near;
    rst = 1'b0; enable = 1'b0; threshold = 16'd0; m_axis_tready = 1'b0;
    cnt_preset = 1'b0; cnt_preset_val = 32'd0;
    repeat (2) @(negedge clk);
    #1;
    check_reset_outputs("por");
    @(negedge clk);
    rst = 1'b1;

    // basic matching record
    threshold = 16'd100;
    set_rec(0, 32'd7, 32'd1234, 16'd50);
    run_batch(1, 1'b0, 0, 1);

    // just above threshold
    set_rec(0, 32'd9, 32'd77, 16'd101);
    run_batch(1, 1'b0, 0, 1);

    // boundaries: equal, zero/zero, all-ones, zero threshold with minval 1
    set_rec(0, 32'hDEAD_BEEF, 32'h8000_0001, 16'd100);
    run_batch(1, 1'b0, 0, 0);
    threshold = 16'd0;
    set_rec(0, 32'hFFFF_FFFF, 32'd0, 16'd0);
    run_batch(1, 1'b0, 0, 0);
    set_rec(0, 32'd3, 32'd4, 16'd1);
    run_batch(1, 1'b0, 0, 0);
    threshold = 16'hFFFF;
    set_rec(0, 32'd5, 32'd6, 16'hFFFF);
    run_batch(1, 1'b0, 0, 0);

    // sink stalls on word1
    threshold = 16'd500;
    set_rec(0, 32'h1111_2222, 32'h3333_4444, 16'd499);
    run_batch(1, 1'b0, 0, 2);

    // FIFO empty after word0 for 10 cycles
    set_rec(0, 32'hA5A5_0001, 32'h0000_BEEF, 16'd600);
    run_batch(1, 1'b0, 10, 1);

    // random back-to-back batches with random backpressure
    for (int b = 0; b < 8; b++) begin
      threshold = 16'($urandom_range(0, 65535));
      k = $urandom_range(1, 3);
      for (int i = 0; i < k; i++) begin
        near = {1'b0, threshold} + 17'($urandom_range(0, 2));
        if ($urandom_range(0, 1) == 0)
          set_rec(i, $urandom, $urandom, 16'($urandom_range(0, 65535)));
        else
          set_rec(i, $urandom, $urandom, (near == 17'd0 || near > 17'h10000) ? 16'hFFFF : 16'(near - 17'd1));
      end
      run_batch(k, 1'b1, 0, 0);
    end

    // reset while stalled in RD_POS
    threshold = 16'd100;
    push(32'h0BAD_0BAD);
    @(negedge clk);
    enable = 1'b1;
    @(negedge clk);
    enable = 1'b0;
    for (int i = 0; i < 20 && rd_ptr != wr_ptr; i++) @(negedge clk);
    @(negedge clk);
    #1;
    check("pre_rst_busy", {63'd0, busy}, 64'd1);
    #1;
    rst = 1'b0;
    #1;
    check_reset_outputs("mid_rst");
    exp_rec = 32'd0;
    exp_match = 32'd0;
    @(negedge clk);
    rst = 1'b1;
    set_rec(0, 32'd42, 32'd4242, 16'd99);
    run_batch(1, 1'b0, 0, 0);

    // counter wrap
    @(negedge clk);
    cnt_preset = 1'b1;
    cnt_preset_val = 32'hFFFF_FFFF;
    @(negedge clk);
    cnt_preset = 1'b0;
    exp_rec = 32'hFFFF_FFFF;
    exp_match = 32'hFFFF_FFFF;
    #1;
    check("preset_nrec", {32'd0, n_records}, {32'd0, exp_rec});
    threshold = 16'd1000;
    set_rec(0, 32'd11, 32'd12, 16'd10);
    set_rec(1, 32'd13, 32'd14, 16'd2000);
    run_batch(2, 1'b1, 0, 1);
    check("wrap_nrec", {32'd0, n_records}, 64'h0000_0000_0000_0001);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
